// File: rtl/election_bonus_manager.sv
// Election-house bonus shield manager: per-tank timed shield with blink
// warning, hit absorption, ammo-refill request and saturating bonus tally.
//
// Ports
//   clk, resetN           clock, async active-low reset
//   start_of_frame        one-cycle frame tick
//   tankNBonus            one-cycle bonus grant
//   tankNHit              one-cycle shell strike
//   tankNRefillAck        refill acknowledge from the tank block
//   tankNShield           shield logically active
//   tankNShieldVisible    shield sprite draw enable
//   tankNHitAbsorbed      one-cycle pulse, hit absorbed by shield
//   tankNRefillReq        ammo-refill request
//   tankNBonusCount[2:0]  saturating bonus tally

module election_bonus_channel #(
  parameter int BONUS_SEC    = 10,
  parameter int SOF_PER_SEC  = 30,
  parameter int WARN_SEC     = 3,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       sof,
  input  logic       bonus,
  input  logic       hit,
  input  logic       ack,
  output logic       shield,
  output logic       visible,
  output logic       hit_absorbed,
  output logic       refill_req,
  output logic [2:0] bonus_count
);

  localparam int TOTAL = BONUS_SEC * SOF_PER_SEC;
  localparam int WARN  = WARN_SEC * SOF_PER_SEC;
  localparam int TW    = $clog2(TOTAL) + 1;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);

  localparam logic [TW-1:0] TOTAL_T = TW'(TOTAL);
  localparam logic [TW-1:0] WARN_T  = TW'(WARN);
  localparam logic [BW-1:0] BLINK_L = BW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WARN_S = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [BW-1:0] blink;

  logic          live;
  logic          ev_load;
  logic          ev_kill;
  logic          ev_tick;
  logic [TW-1:0] timer_dec;

  // Event decode is made one-hot: a bonus overrides a hit, and both
  // override the frame tick, so the reload never also decrements.
  assign live      = (state != IDLE);
  assign ev_load   = bonus;
  assign ev_kill   = hit & live & ~bonus;
  assign ev_tick   = sof & live & ~bonus & ~(hit & live);
  assign timer_dec = timer - TW'(1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      timer        <= '0;
      blink        <= '0;
      shield       <= 1'b0;
      visible      <= 1'b0;
      hit_absorbed <= 1'b0;
    end else begin
      hit_absorbed <= 1'b0;
      unique case (1'b1)
        ev_load: begin
          state        <= ACTIVE;
          timer        <= TOTAL_T;
          blink        <= '0;
          shield       <= 1'b1;
          visible      <= 1'b1;
          hit_absorbed <= hit & live;
        end
        ev_kill: begin
          state        <= IDLE;
          timer        <= '0;
          blink        <= '0;
          shield       <= 1'b0;
          visible      <= 1'b0;
          hit_absorbed <= 1'b1;
        end
        ev_tick: begin
          timer <= timer_dec;
          if (timer_dec == '0) begin
            state   <= IDLE;
            blink   <= '0;
            shield  <= 1'b0;
            visible <= 1'b0;
          end else if (state == ACTIVE &&
                       timer_dec == WARN_T) begin
            // Blink phase restarts solid on WARN entry.
            state   <= WARN_S;
            blink   <= '0;
            visible <= 1'b1;
          end else if (state == WARN_S) begin
            if (blink == BLINK_L) begin
              blink   <= '0;
              visible <= ~visible;
            end else begin
              blink <= blink + BW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A bonus re-asserts the request even on the cycle an ack would drop
  // it; no second request is queued.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      refill_req <= 1'b0;
    end else if (bonus) begin
      refill_req <= 1'b1;
    end else if (ack) begin
      refill_req <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bonus_count <= 3'd0;
    end else if (bonus && bonus_count != 3'd7) begin
      bonus_count <= bonus_count + 3'd1;
    end
  end

endmodule

module election_bonus_manager #(
  parameter int BONUS_SEC    = 10,
  parameter int SOF_PER_SEC  = 30,
  parameter int WARN_SEC     = 3,
  parameter int BLINK_FRAMES = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_of_frame,
  input  logic       tank1Bonus,
  input  logic       tank2Bonus,
  input  logic       tank1Hit,
  input  logic       tank2Hit,
  input  logic       tank1RefillAck,
  input  logic       tank2RefillAck,
  output logic       tank1Shield,
  output logic       tank2Shield,
  output logic       tank1ShieldVisible,
  output logic       tank2ShieldVisible,
  output logic       tank1HitAbsorbed,
  output logic       tank2HitAbsorbed,
  output logic       tank1RefillReq,
  output logic       tank2RefillReq,
  output logic [2:0] tank1BonusCount,
  output logic [2:0] tank2BonusCount
);

  election_bonus_channel #(
    .BONUS_SEC    (BONUS_SEC),
    .SOF_PER_SEC  (SOF_PER_SEC),
    .WARN_SEC     (WARN_SEC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_ch1 (
    .clk          (clk),
    .resetN       (resetN),
    .sof          (start_of_frame),
    .bonus        (tank1Bonus),
    .hit          (tank1Hit),
    .ack          (tank1RefillAck),
    .shield       (tank1Shield),
    .visible      (tank1ShieldVisible),
    .hit_absorbed (tank1HitAbsorbed),
    .refill_req   (tank1RefillReq),
    .bonus_count  (tank1BonusCount)
  );

  election_bonus_channel #(
    .BONUS_SEC    (BONUS_SEC),
    .SOF_PER_SEC  (SOF_PER_SEC),
    .WARN_SEC     (WARN_SEC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_ch2 (
    .clk          (clk),
    .resetN       (resetN),
    .sof          (start_of_frame),
    .bonus        (tank2Bonus),
    .hit          (tank2Hit),
    .ack          (tank2RefillAck),
    .shield       (tank2Shield),
    .visible      (tank2ShieldVisible),
    .hit_absorbed (tank2HitAbsorbed),
    .refill_req   (tank2RefillReq),
    .bonus_count  (tank2BonusCount)
  );

endmodule

// File: doc/election_bonus_manager.md
ELECTION_BONUS_MANAGER -- requirements
Module: election_bonus_manager

Interface
REQ-001 Parameter BONUS_SEC, default 10, shield duration in seconds.
REQ-002 Parameter SOF_PER_SEC, default 30, start_of_frame pulses per second.
REQ-003 Parameter WARN_SEC, default 3, final shield seconds during which the shield blinks.
REQ-004 Parameter BLINK_FRAMES, default 8, frames per blink half-period.
REQ-005 Port clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-006 Port resetN  in  1  asynchronous, active-low reset.
REQ-007 Port start_of_frame  in  1  one-cycle frame tick.
REQ-008 Ports tank1Bonus, tank2Bonus  in  1 each  one-cycle bonus-grant pulse from the election-house counter.
REQ-009 Ports tank1Hit, tank2Hit  in  1 each  one-cycle pulse, tank struck by a shell.
REQ-010 Ports tank1RefillAck, tank2RefillAck  in  1 each  ammo-refill acknowledge from the tank block.
REQ-011 Ports tank1Shield, tank2Shield  out  1 each  shield logically active.
REQ-012 Ports tank1ShieldVisible, tank2ShieldVisible  out  1 each  shield sprite draw enable.
REQ-013 Ports tank1HitAbsorbed, tank2HitAbsorbed  out  1 each  one-cycle pulse, hit absorbed by the shield.
REQ-014 Ports tank1RefillReq, tank2RefillReq  out  1 each  ammo-refill request.
REQ-015 Ports tank1BonusCount, tank2BonusCount  out  3 each  saturating bonus tally.

Function
REQ-016 Each tank SHALL have an independent, identical channel; the tank-1 and tank-2 channels SHALL not interact.
REQ-017 Each channel SHALL implement the FSM states IDLE, ACTIVE and WARN, plus a frame timer sized for BONUS_SEC*SOF_PER_SEC (10 bits at defaults).
REQ-018 On a Bonus pulse in any state, the channel SHALL load timer=BONUS_SEC*SOF_PER_SEC (300) and go to ACTIVE on the next edge.
REQ-019 On start_of_frame in ACTIVE or WARN, the timer SHALL decrement by 1; the channel SHALL leave the timer unchanged in IDLE.
REQ-020 ACTIVE SHALL go to WARN on the tick that makes timer == WARN_SEC*SOF_PER_SEC (90).
REQ-021 WARN or ACTIVE SHALL go to IDLE on the tick that makes timer == 0.
REQ-022 A Hit in ACTIVE or WARN SHALL force IDLE with timer=0 and pulse HitAbsorbed for exactly 1 cycle on the next edge.
REQ-023 A Hit in IDLE SHALL produce no HitAbsorbed pulse and no state change.
REQ-024 Bonus and Hit in the same cycle: Bonus wins (reload, ACTIVE), and the channel SHALL still pulse HitAbsorbed if the prior state was not IDLE.
REQ-025 Bonus and start_of_frame in the same cycle: reload wins and the channel SHALL not decrement.
REQ-026 Shield SHALL be high exactly when the state is not IDLE (registered).
REQ-027 ShieldVisible SHALL be 1 in ACTIVE and 0 in IDLE.
REQ-028 In WARN, ShieldVisible SHALL start at 1 on WARN entry and toggle every BLINK_FRAMES ticks.
REQ-029 Each channel SHALL reset its blink counter on WARN entry.
REQ-030 On a Bonus pulse, the channel SHALL set RefillReq high from the next edge and hold it until Ack is sampled high.
REQ-031 RefillReq SHALL drop on the edge after Ack is sampled high.
REQ-032 A Bonus while RefillReq is already high SHALL keep RefillReq high, with no queueing of a second request.
REQ-033 An Ack while RefillReq is low SHALL be ignored.
REQ-034 A Bonus on the same cycle RefillReq drops due to Ack SHALL keep RefillReq high.
REQ-035 Each Bonus pulse SHALL increment BonusCount, saturating at 7.
REQ-036 Every output SHALL be registered.

Reset
REQ-037 resetN low SHALL asynchronously force every output to 0, every state to IDLE, and timers, blink counters and tallies to 0.
REQ-038 Reset mid-shield or with RefillReq pending SHALL abandon the shield and the request, with no pulse emitted after release.

Verification
REQ-039 tank1Bonus pulse, then 300 ticks -> tank1Shield=1 for exactly 300 ticks.
REQ-040 Same as REQ-039 -> tank1ShieldVisible=1 until tick 210, then blinks 8-tick halves, then 0.
REQ-041 tank2Bonus, then tank2Hit at tick 50 -> tank2Shield=0 next edge, single-cycle tank2HitAbsorbed, timer 0.
REQ-042 tank1Bonus at tick 250, second Bonus at tick 280 -> shield returns to ACTIVE with timer 300, visible=1 solid, BonusCount=2.
REQ-043 Bonus, then Ack held low 20 cycles, then Ack high 1 cycle -> RefillReq high 20+1 cycles, then low.
REQ-044 Ack with no request -> RefillReq stays 0.
REQ-045 Nine Bonus pulses -> BonusCount sticks at 7.
REQ-046 resetN low mid-WARN -> all outputs 0 immediately, with no spurious pulses after release.
